// File: rtl/icmp_pipe_if.sv
// Handshake/bus bundle for icmp_pipe: input transfer channel and result channel.
// Optional reduce outputs exist only when ICMP_PIPE_REDUCE_EN is defined.
interface icmp_pipe_if #(
  parameter int unsigned ParamBitWidth = 32,
  parameter int unsigned ParamLanes    = 1
) ();
  logic                                in_valid;
  logic                                in_ready;
  logic [3:0]                          in_op;
  logic [ParamLanes*ParamBitWidth-1:0] lhs;
  logic [ParamLanes*ParamBitWidth-1:0] rhs;
  logic                                out_valid;
  logic                                out_ready;
  logic [ParamLanes-1:0]               ret;
  logic                                op_err;
`ifdef ICMP_PIPE_REDUCE_EN
  logic                                ret_any;
  logic                                ret_all;
`endif

  // Producer of transfers / consumer of results
  modport master (
    output in_valid, in_op, lhs, rhs, out_ready,
    input  in_ready, out_valid, ret, op_err
`ifdef ICMP_PIPE_REDUCE_EN
    , input ret_any, ret_all
`endif
  );

  // The compare pipeline itself
  modport slave (
    input  in_valid, in_op, lhs, rhs, out_ready,
    output in_ready, out_valid, ret, op_err
`ifdef ICMP_PIPE_REDUCE_EN
    , output ret_any, ret_all
`endif
  );
endinterface

// File: rtl/icmp_pipe.sv
// icmp_pipe: multi-lane LLVM-style integer compare with a valid/ready pipeline.
// Stage 1 evaluates the predicate; later stages only delay. Bubbles collapse.
// Optional feature macro: ICMP_PIPE_REDUCE_EN adds ret_any / ret_all outputs.
module icmp_pipe #(
  parameter int unsigned ParamBitWidth = 32,
  parameter int unsigned ParamLanes    = 1,
  parameter int unsigned ParamLatency  = 2
) (
  input logic        clk,
  input logic        reset,
  icmp_pipe_if.slave bus
);
  localparam int unsigned W = ParamBitWidth;
  localparam int unsigned L = ParamLanes;
  localparam int unsigned D = ParamLatency;
  localparam logic [3:0]  OpMax = 4'd9;

  logic [W-1:0]        lane_a;
  logic [W-1:0]        lane_b;
  logic [L-1:0]        ret_c;
  logic                err_c;
  logic [D-1:0]        adv_c;
  logic [D-1:0]        load_c;

  logic [D-1:0]        v_q, v_d;
  logic [D-1:0][L-1:0] ret_q, ret_d;
  logic [D-1:0]        err_q, err_d;
`ifdef ICMP_PIPE_REDUCE_EN
  logic                any_c, all_c;
  logic [D-1:0]        any_q, any_d;
  logic [D-1:0]        all_q, all_d;
`endif

  // Per-lane predicate evaluation; unknown opcodes yield all-zero results
  always_comb begin
    ret_c  = '0;
    lane_a = '0;
    lane_b = '0;
    err_c  = (bus.in_op > OpMax);
    for (int i = 0; i < int'(L); i++) begin
      lane_a = bus.lhs[i*W +: W];
      lane_b = bus.rhs[i*W +: W];
      case (bus.in_op)
        4'd0:    ret_c[i] = (lane_a == lane_b);
        4'd1:    ret_c[i] = (lane_a != lane_b);
        4'd2:    ret_c[i] = (lane_a >  lane_b);
        4'd3:    ret_c[i] = (lane_a >= lane_b);
        4'd4:    ret_c[i] = (lane_a <  lane_b);
        4'd5:    ret_c[i] = (lane_a <= lane_b);
        4'd6:    ret_c[i] = ($signed(lane_a) >  $signed(lane_b));
        4'd7:    ret_c[i] = ($signed(lane_a) >= $signed(lane_b));
        4'd8:    ret_c[i] = ($signed(lane_a) <  $signed(lane_b));
        4'd9:    ret_c[i] = ($signed(lane_a) <= $signed(lane_b));
        default: ret_c[i] = 1'b0;
      endcase
    end
  end

`ifdef ICMP_PIPE_REDUCE_EN
  // Lane reductions, suppressed for an invalid opcode
  always_comb begin
    any_c = (|ret_c) & ~err_c;
    all_c = (&ret_c) & ~err_c;
  end
`endif

  // Stage advance: a stage may move if any later stage is empty or the output drains
  always_comb begin
    logic run;
    run         = bus.out_ready;
    adv_c       = '0;
    adv_c[D-1]  = run;
    for (int k = int'(D) - 2; k >= 0; k--) begin
      run      = run | ~v_q[k+1];
      adv_c[k] = run;
    end
    load_c = ~v_q | adv_c;
  end

  // Next-state for every stage; stage 0 takes the fresh compare result
  always_comb begin
    v_d   = v_q;
    ret_d = ret_q;
    err_d = err_q;
`ifdef ICMP_PIPE_REDUCE_EN
    any_d = any_q;
    all_d = all_q;
`endif
    if (load_c[0]) begin
      v_d[0]   = bus.in_valid;
      ret_d[0] = ret_c;
      err_d[0] = err_c;
`ifdef ICMP_PIPE_REDUCE_EN
      any_d[0] = any_c;
      all_d[0] = all_c;
`endif
    end
    for (int k = 1; k < int'(D); k++) begin
      if (load_c[k]) begin
        v_d[k]   = v_q[k-1];
        ret_d[k] = ret_q[k-1];
        err_d[k] = err_q[k-1];
`ifdef ICMP_PIPE_REDUCE_EN
        any_d[k] = any_q[k-1];
        all_d[k] = all_q[k-1];
`endif
      end
    end
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      ret_q <= '0;
      err_q <= '0;
`ifdef ICMP_PIPE_REDUCE_EN
      any_q <= '0;
      all_q <= '0;
`endif
    end else begin
      v_q   <= v_d;
      ret_q <= ret_d;
      err_q <= err_d;
`ifdef ICMP_PIPE_REDUCE_EN
      any_q <= any_d;
      all_q <= all_d;
`endif
    end
  end

  assign bus.in_ready  = load_c[0];
  assign bus.out_valid = v_q[D-1];
  assign bus.ret       = ret_q[D-1];
  assign bus.op_err    = err_q[D-1];
`ifdef ICMP_PIPE_REDUCE_EN
  assign bus.ret_any   = any_q[D-1];
  assign bus.ret_all   = all_q[D-1];
`endif
endmodule

// File: tb/tb_icmp_pipe.sv
// Bench for icmp_pipe: two instances (W=8/L=1/Lat=2 and W=16/L=4/Lat=3),
// table-driven vectors with a queue scoreboard plus hand-written corner sequences.
module tb_icmp_pipe;
  localparam int LatA = 2;
  localparam int LatB = 3;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] lhs;
    logic [63:0] rhs;
    logic [3:0]  ret;
    logic        err;
  } vec_t;

  typedef struct {
    logic [3:0] ret;
    logic       err;
    bit         chk_lat;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t pend_a, pend_b, ea, eb;
  vec_t tab_a[24];
  vec_t tab_b[6];

  icmp_pipe_if #(.ParamBitWidth(8),  .ParamLanes(1)) if_a ();
  icmp_pipe_if #(.ParamBitWidth(16), .ParamLanes(4)) if_b ();

  icmp_pipe #(.ParamBitWidth(8), .ParamLanes(1), .ParamLatency(LatA)) u_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  icmp_pipe #(.ParamBitWidth(16), .ParamLanes(4), .ParamLatency(LatB)) u_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mkv(input logic [3:0] op, input logic [63:0] l, input logic [63:0] r,
                               input logic [3:0] ret, input logic err);
    vec_t v;
    v.op = op; v.lhs = l; v.rhs = r; v.ret = ret; v.err = err;
    return v;
  endfunction

  // Scoreboard for instance A: push on accept, pop and compare on consume
  always @(negedge clk) begin
    if (!reset) begin
      if (if_a.in_valid && if_a.in_ready) begin
        ea = pend_a;
        ea.acc = cyc + 1;
        exp_a.push_back(ea);
      end
      if (if_a.out_valid && if_a.out_ready) begin
        if (exp_a.size() == 0) begin
          check("a_unexpected_out", 64'(if_a.out_valid), 64'd0);
        end else begin
          ea = exp_a.pop_front();
          check("a_ret", 64'(if_a.ret), 64'(ea.ret));
          check("a_err", 64'(if_a.op_err), 64'(ea.err));
          if (ea.chk_lat) check("a_latency", 64'(cyc + 1 - ea.acc), 64'(LatA));
        end
      end
    end
  end

  // Scoreboard for instance B
  always @(negedge clk) begin
    if (!reset) begin
      if (if_b.in_valid && if_b.in_ready) begin
        eb = pend_b;
        eb.acc = cyc + 1;
        exp_b.push_back(eb);
      end
      if (if_b.out_valid && if_b.out_ready) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected_out", 64'(if_b.out_valid), 64'd0);
        end else begin
          eb = exp_b.pop_front();
          check("b_ret", 64'(if_b.ret), 64'(eb.ret));
          check("b_err", 64'(if_b.op_err), 64'(eb.err));
          if (eb.chk_lat) check("b_latency", 64'(cyc + 1 - eb.acc), 64'(LatB));
        end
      end
    end
  end

  // Offer one transfer on A and hold it until accepted (bounded)
  task automatic drive_a(input vec_t v, input bit chk);
    bit acc;
    int n;
    if_a.in_valid = 1'b1;
    if_a.in_op    = v.op;
    if_a.lhs      = v.lhs[7:0];
    if_a.rhs      = v.rhs[7:0];
    pend_a.ret    = v.ret;
    pend_a.err    = v.err;
    pend_a.chk_lat = chk;
    pend_a.acc    = 0;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = if_a.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if_a.in_valid = 1'b0;
    if (!acc) check("a_accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic set_b(input vec_t v);
    if_b.in_valid  = 1'b1;
    if_b.in_op     = v.op;
    if_b.lhs       = v.lhs;
    if_b.rhs       = v.rhs;
    pend_b.ret     = v.ret;
    pend_b.err     = v.err;
    pend_b.chk_lat = 1'b0;
    pend_b.acc     = 0;
  endtask

  task automatic drain(input bit is_b);
    int n = 0;
    while (((is_b ? exp_b.size() : exp_a.size()) != 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(is_b ? "b_drain" : "a_drain", 64'(is_b ? exp_b.size() : exp_a.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int idx;
    reset = 1'b1;
    if_a.in_valid = 1'b0; if_a.in_op = '0; if_a.lhs = '0; if_a.rhs = '0; if_a.out_ready = 1'b1;
    if_b.in_valid = 1'b0; if_b.in_op = '0; if_b.lhs = '0; if_b.rhs = '0; if_b.out_ready = 1'b1;
    pend_a = '{ret: 4'd0, err: 1'b0, chk_lat: 1'b0, acc: 0};
    pend_b = pend_a;

    // Vectors for A: opcode sweep, equal-operand boundaries, sign boundary, bad opcode
    k = 0;
    tab_a[k++] = mkv(4'd0, 64'h80, 64'h01, 4'd0, 1'b0);
    tab_a[k++] = mkv(4'd1, 64'h80, 64'h01, 4'd1, 1'b0);
    tab_a[k++] = mkv(4'd2, 64'h80, 64'h01, 4'd1, 1'b0);
    tab_a[k++] = mkv(4'd3, 64'h80, 64'h01, 4'd1, 1'b0);
    tab_a[k++] = mkv(4'd4, 64'h80, 64'h01, 4'd0, 1'b0);
    tab_a[k++] = mkv(4'd5, 64'h80, 64'h01, 4'd0, 1'b0);
    tab_a[k++] = mkv(4'd6, 64'h80, 64'h01, 4'd0, 1'b0);
    tab_a[k++] = mkv(4'd7, 64'h80, 64'h01, 4'd0, 1'b0);
    tab_a[k++] = mkv(4'd8, 64'h80, 64'h01, 4'd1, 1'b0);
    tab_a[k++] = mkv(4'd9, 64'h80, 64'h01, 4'd1, 1'b0);
    tab_a[k++] = mkv(4'd2, 64'h7F, 64'h7F, 4'd0, 1'b0);
    tab_a[k++] = mkv(4'd3, 64'h7F, 64'h7F, 4'd1, 1'b0);
    tab_a[k++] = mkv(4'd4, 64'h7F, 64'h7F, 4'd0, 1'b0);
    tab_a[k++] = mkv(4'd5, 64'h7F, 64'h7F, 4'd1, 1'b0);
    tab_a[k++] = mkv(4'd6, 64'h7F, 64'h7F, 4'd0, 1'b0);
    tab_a[k++] = mkv(4'd7, 64'h7F, 64'h7F, 4'd1, 1'b0);
    tab_a[k++] = mkv(4'd8, 64'h7F, 64'h7F, 4'd0, 1'b0);
    tab_a[k++] = mkv(4'd9, 64'h7F, 64'h7F, 4'd1, 1'b0);
    tab_a[k++] = mkv(4'd2, 64'hFF, 64'h00, 4'd1, 1'b0);
    tab_a[k++] = mkv(4'd6, 64'hFF, 64'h00, 4'd0, 1'b0);
    tab_a[k++] = mkv(4'd8, 64'hFF, 64'h00, 4'd1, 1'b0);
    tab_a[k++] = mkv(4'd4, 64'h00, 64'hFF, 4'd1, 1'b0);
    tab_a[k++] = mkv(4'd12, 64'h80, 64'h01, 4'd0, 1'b1);
    tab_a[k++] = mkv(4'd0, 64'h55, 64'h55, 4'd1, 1'b0);

    // Vectors for B (lane 0 in the low 16 bits)
    tab_b[0] = mkv(4'd8,  64'h7FFF_8000_0001_FFFF, 64'h8000_7FFF_0001_0000, 4'b0101, 1'b0);
    tab_b[1] = mkv(4'd4,  64'h7FFF_8000_0001_FFFF, 64'h8000_7FFF_0001_0000, 4'b1000, 1'b0);
    tab_b[2] = mkv(4'd0,  64'h7FFF_8000_0001_FFFF, 64'h8000_7FFF_0001_0000, 4'b0010, 1'b0);
    tab_b[3] = mkv(4'd1,  64'h7FFF_8000_0001_FFFF, 64'h8000_7FFF_0001_0000, 4'b1101, 1'b0);
    tab_b[4] = mkv(4'd6,  64'h7FFF_8000_0001_FFFF, 64'h8000_7FFF_0001_0000, 4'b1000, 1'b0);
    tab_b[5] = mkv(4'd13, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 4'b0000, 1'b1);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("a_rst_out_valid", 64'(if_a.out_valid), 64'd0);
    check("a_rst_ret",       64'(if_a.ret),       64'd0);
    check("a_rst_op_err",    64'(if_a.op_err),    64'd0);
    check("a_rst_in_ready",  64'(if_a.in_ready),  64'd1);
    check("b_rst_out_valid", 64'(if_b.out_valid), 64'd0);
    check("b_rst_ret",       64'(if_b.ret),       64'd0);
    check("b_rst_op_err",    64'(if_b.op_err),    64'd0);
    check("b_rst_in_ready",  64'(if_b.in_ready),  64'd1);
    @(posedge clk);
    #1;

    // Back-to-back table stream on A with latency checks
    for (int i = 0; i < 24; i++) drive_a(tab_a[i], 1'b1);
    drain(1'b0);

    // Backpressure on B: only the pipeline depth gets in while the output is stalled
    if_b.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 6) set_b(tab_b[idx]); else if_b.in_valid = 1'b0;
      @(negedge clk);
      if (if_b.in_valid && if_b.in_ready) idx++;
      @(posedge clk);
      #1;
    end
    check("b_accepted_when_stalled", 64'(idx), 64'd3);
    @(negedge clk);
    check("b_full_in_ready",   64'(if_b.in_ready),  64'd0);
    check("b_full_out_valid",  64'(if_b.out_valid), 64'd1);
    check("b_stall_ret",       64'(if_b.ret),       64'(4'b0101));
    @(negedge clk);
    check("b_stall_ret_hold",  64'(if_b.ret),       64'(4'b0101));
    check("b_stall_err_hold",  64'(if_b.op_err),    64'd0);
    @(posedge clk);
    #1;
    if_b.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (idx < 6) set_b(tab_b[idx]); else if_b.in_valid = 1'b0;
      @(negedge clk);
      check("b_no_gap", 64'(if_b.out_valid), 64'd1);
      if (if_b.in_valid && if_b.in_ready) idx++;
      @(posedge clk);
      #1;
    end
    if_b.in_valid = 1'b0;
    check("b_all_accepted", 64'(idx), 64'd6);
    drain(1'b1);

    // Reset with two transfers in flight on A: nothing may come out for them
    if_a.out_ready = 1'b0;
    drive_a(mkv(4'd0, 64'h11, 64'h11, 4'd1, 1'b0), 1'b0);
    drive_a(mkv(4'd4, 64'h01, 64'h02, 4'd1, 1'b0), 1'b0);
    reset = 1'b1;
    exp_a.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("a_midrst_out_valid", 64'(if_a.out_valid), 64'd0);
    check("a_midrst_in_ready",  64'(if_a.in_ready),  64'd1);
    if_a.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    drive_a(mkv(4'd5, 64'h10, 64'h10, 4'd1, 1'b0), 1'b1);
    drain(1'b0);

    check("a_queue_empty", 64'(exp_a.size()), 64'd0);
    check("b_queue_empty", 64'(exp_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
